// File: rtl/cfg_stream_tx_pkg.sv
// ---------------------------------------------------------------------------
// cfg_stream_tx_pkg
//   Shared definitions for the NovaCORE configuration-port transmitter:
//   default bus widths, the transmitter FSM state encoding and a helper that
//   sizes the shared down-counter.
// ---------------------------------------------------------------------------
package cfg_stream_tx_pkg;

    localparam int DATA_W_DEF = 18;
    localparam int UID_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MSU  = 3'd1,
        ST_LOAD = 3'd2,
        ST_LOW  = 3'd3,
        ST_HIGH = 3'd4,
        ST_TAIL = 3'd5
    } state_t;

    // Counter must hold DIV-1 and MODE_SU-1; never narrower than one bit.
    function automatic int cnt_width(input int div, input int msu);
        int m;
        m = (div > msu) ? div : msu;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cfg_stream_tx_fifo.sv
// ---------------------------------------------------------------------------
// cfg_fifo
//   Synchronous FIFO buffering (last, uid, word) tuples ahead of the
//   transmitter FSM. Read data is presented combinationally from the head.
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset; flushes all contents
//   push_i   in   write wdata_i this cycle
//   wdata_i  in   tuple to store
//   pop_i    in   drop the head entry this cycle
//   rdata_o  out  head entry (valid when empty_o = 0)
//   full_o   out  registered full flag (held high during reset)
//   empty_o  out  no entries stored
// ---------------------------------------------------------------------------
module cfg_fifo #(
    parameter int W     = 23,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    // A push into a full FIFO still succeeds when the head leaves the same cycle.
    assign do_push = push_i && ((cnt_q != DEPTH_C) || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            // Reported full while in reset so the producer sees no ready.
            full_q   <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cfg_stream_tx.sv
// ---------------------------------------------------------------------------
// cfg_stream_tx
//   Transmitter side of the NovaCORE configuration port. Buffers
//   (uid, word, last) tuples from the loader and, per session, drives mode,
//   c_bus, c_uid and the c_clk strobe sampled by the fabric on its rising edge.
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   start     in   begins a session (ignored while busy or in the done cycle)
//   in_valid  in   tuple valid
//   in_ready  out  tuple accepted on in_valid & in_ready (input FIFO not full)
//   in_uid    in   target unit id
//   in_data   in   configuration word
//   in_last   in   final tuple of the session
//   mode      out  configuration mode to fabric
//   c_bus     out  configuration data to fabric
//   c_uid     out  configuration unit id to fabric
//   c_clk     out  configuration strobe to fabric
//   busy      out  session in progress
//   done      out  one-cycle pulse at session end
// ---------------------------------------------------------------------------
module cfg_stream_tx
    import cfg_stream_tx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int UID_W      = UID_W_DEF,
    parameter int DIV        = 4,
    parameter int MODE_SU    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [UID_W-1:0]  in_uid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              mode,
    output logic [DATA_W-1:0] c_bus,
    output logic [UID_W-1:0]  c_uid,
    output logic              c_clk,
    output logic              busy,
    output logic              done
);

    localparam int TUP_W = UID_W + DATA_W + 1;
    localparam int CNT_W = cnt_width(DIV, MODE_SU);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] MSU_LD = CNT_W'(MODE_SU - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              c_clk_q, c_clk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic [UID_W-1:0]  uid_q, uid_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TUP_W-1:0]  fifo_wdata, fifo_rdata;
    logic              fifo_last;
    logic [UID_W-1:0]  fifo_uid;
    logic [DATA_W-1:0] fifo_data;

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign fifo_wdata = {in_last, in_uid, in_data};
    assign {fifo_last, fifo_uid, fifo_data} = fifo_rdata;

    cfg_fifo #(
        .W     (TUP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        c_clk_d  = c_clk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        last_d   = last_q;
        bus_d    = bus_q;
        uid_d    = uid_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mode_d  = 1'b0;
                c_clk_d = 1'b0;
                busy_d  = 1'b0;
                // done_q marks the completion cycle; a start there is dropped.
                if (start && !done_q) begin
                    state_d = ST_MSU;
                    busy_d  = 1'b1;
                    mode_d  = 1'b1;
                    cnt_d   = MSU_LD;
                end
            end
            ST_MSU: begin
                if (cnt_q == '0) state_d = ST_LOAD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_LOAD: begin
                // Empty FIFO stalls here with c_clk low and the bus held.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    bus_d    = fifo_data;
                    uid_d    = fifo_uid;
                    last_d   = fifo_last;
                    state_d  = ST_LOW;
                    cnt_d    = DIV_LD;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    c_clk_d = 1'b1;
                    cnt_d   = DIV_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    c_clk_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_TAIL;
                        cnt_d   = DIV_LD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TAIL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    mode_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            c_clk_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            bus_q   <= '0;
            uid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            c_clk_q <= c_clk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
            bus_q   <= bus_d;
            uid_q   <= uid_d;
        end
    end

    assign mode  = mode_q;
    assign c_bus = bus_q;
    assign c_uid = uid_q;
    assign c_clk = c_clk_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_cfg_stream_tx.sv
module tb_cfg_stream_tx;

    localparam int DATA_W     = 18;
    localparam int UID_W      = 4;
    localparam int DIV        = 4;
    localparam int MODE_SU    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BUDGET     = 400;
    localparam int WORD       = (1 + 2 * DIV);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [UID_W-1:0]  in_uid = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              mode;
    logic [DATA_W-1:0] c_bus;
    logic [UID_W-1:0]  c_uid;
    logic              c_clk;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    cfg_stream_tx #(
        .DATA_W     (DATA_W),
        .UID_W      (UID_W),
        .DIV        (DIV),
        .MODE_SU    (MODE_SU),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_uid   (in_uid),
        .in_data  (in_data),
        .in_last  (in_last),
        .mode     (mode),
        .c_bus    (c_bus),
        .c_uid    (c_uid),
        .c_clk    (c_clk),
        .busy     (busy),
        .done     (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: tuples accepted by the port, in the order the fabric must see them.
    logic [UID_W+DATA_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Fabric-side observer: every c_clk rising edge must present the next
    // accepted tuple, held stable for exactly DIV cycles.
    logic                    mon_prev = 1'b0;
    int                      hi_len = 0;
    logic [UID_W+DATA_W-1:0] hi_word = '0;
    logic [UID_W+DATA_W-1:0] mon_w;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = 1'b0;
                hi_len   = 0;
            end else begin
                if (c_clk && !mon_prev) begin
                    hi_word = {c_uid, c_bus};
                    hi_len  = 1;
                    if (exp_q.size() == 0) begin
                        chk("edge_unexpected", 32'd1, 32'd0);
                    end else begin
                        mon_w = exp_q.pop_front();
                        chk("edge_uid", 32'(c_uid), 32'(mon_w[UID_W+DATA_W-1:DATA_W]));
                        chk("edge_data", 32'(c_bus), 32'(mon_w[DATA_W-1:0]));
                    end
                end else if (c_clk) begin
                    hi_len++;
                    chk("hold_stable", 32'({c_uid, c_bus}), 32'(hi_word));
                end else if (mon_prev) begin
                    chk("high_len", hi_len, DIV);
                end
                mon_prev = c_clk;
            end
        end
    end

    // Offer one tuple and hold it until accepted (bounded).
    task automatic push_wait(input logic [UID_W-1:0] u, input logic [DATA_W-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_uid   = u;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (in_ready) ok = 1'b1;
            else          @(negedge clk);
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        else     exp_q.push_back({u, d});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pulse start and follow the session to done. Observation index k = 0 is
    // the first cycle after the edge that samples start.
    task automatic run_session(input string tag, input int n_words, input int push_at,
                               input logic [UID_W-1:0] lu, input logic [DATA_W-1:0] ld,
                               input logic [DATA_W-1:0] stall_bus,
                               input int busy_start_k, input bit start_at_done);
        int   rises[$];
        int   done_k;
        int   exp_done;
        logic prev;
        done_k = -1;
        prev   = 1'b0;
        chk({tag, "_mode_pre"}, 32'(mode), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < BUDGET && done_k < 0; k++) begin
            if (k == 0) begin
                chk({tag, "_mode_rise"}, 32'(mode), 32'd1);
                chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
            end
            if (c_clk && !prev) rises.push_back(k);
            prev = c_clk;
            if (push_at >= 0 && k == push_at) begin
                chk({tag, "_stall_clk"}, 32'(c_clk), 32'd0);
                chk({tag, "_stall_bus"}, 32'(c_bus), 32'(stall_bus));
                in_valid = 1'b1;
                in_uid   = lu;
                in_data  = ld;
                in_last  = 1'b1;
                if (in_ready) exp_q.push_back({lu, ld});
                else          chk({tag, "_late_ready"}, 32'd0, 32'd1);
            end
            if (push_at >= 0 && k == push_at + 1) in_valid = 1'b0;
            if (busy_start_k >= 0) begin
                if (k == busy_start_k)     start = 1'b1;
                if (k == busy_start_k + 1) start = 1'b0;
            end
            if (done) done_k = k;
            else      @(negedge clk);
        end
        if (done_k < 0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        exp_done = (push_at < 0) ? (MODE_SU + n_words * WORD + DIV) : (push_at + 2 + 3 * DIV);
        chk({tag, "_done_time"}, done_k, exp_done);
        chk({tag, "_edges"}, rises.size(), n_words);
        if (rises.size() > 0 && (push_at < 0 || n_words > 1))
            chk({tag, "_first_rise"}, rises[0], MODE_SU + 1 + DIV);
        if (rises.size() > 0 && push_at >= 0)
            chk({tag, "_late_rise"}, rises[rises.size()-1], push_at + 2 + DIV);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_mode_at_done"}, 32'(mode), 32'd0);
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        if (start_at_done) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_busy_after"}, 32'(busy), 32'd0);
                chk({tag, "_mode_after"}, 32'(mode), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_c_bus"}, 32'(c_bus), 32'd0);
        chk({tag, "_c_uid"}, 32'(c_uid), 32'd0);
        chk({tag, "_c_clk"}, 32'(c_clk), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    logic [UID_W-1:0]  t4u [6];
    logic [DATA_W-1:0] t4d [6];

    initial begin
        int          acc;
        bit          dropped;
        bit          seen_hi;
        int          n;
        logic [DATA_W-1:0] d1;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // 1: single tuple
        push_wait(4'd3, 18'h2A5A5, 1'b1);
        run_session("t1", 1, -1, '0, '0, '0, -1, 1'b0);

        // 2: three tuples
        push_wait(4'd0, 18'd1, 1'b0);
        push_wait(4'd1, 18'd2, 1'b0);
        push_wait(4'd2, 18'd3, 1'b1);
        run_session("t2", 3, -1, '0, '0, '0, -1, 1'b0);

        // 3: underflow stall, second tuple arrives 20 cycles in
        d1 = DATA_W'($urandom);
        push_wait(UID_W'($urandom), d1, 1'b0);
        run_session("t3", 2, 20, UID_W'($urandom), DATA_W'($urandom), d1, -1, 1'b0);

        // 4: back-pressure with six tuples offered while idle
        for (int i = 0; i < 6; i++) begin
            t4u[i] = UID_W'($urandom);
            t4d[i] = DATA_W'($urandom);
        end
        acc = 0;
        dropped = 1'b0;
        for (int i = 0; i < 10 && !dropped && acc < 6; i++) begin
            in_valid = 1'b1;
            in_uid   = t4u[acc];
            in_data  = t4d[acc];
            in_last  = (acc == 5);
            if (in_ready) begin
                exp_q.push_back({t4u[acc], t4d[acc]});
                acc++;
                @(negedge clk);
            end else begin
                dropped = 1'b1;
            end
        end
        chk("t4_ready_low", 32'(in_ready), 32'd0);
        chk("t4_accepted", acc, FIFO_DEPTH);
        fork
            begin
                for (int j = acc; j < 6; j++) push_wait(t4u[j], t4d[j], (j == 5));
            end
            run_session("t4", 6, -1, '0, '0, '0, -1, 1'b0);
        join
        chk("t4_all_emitted", exp_q.size(), 0);

        // 5: reset during a HIGH phase
        push_wait(UID_W'($urandom), DATA_W'($urandom), 1'b0);
        push_wait(UID_W'($urandom), DATA_W'($urandom), 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_hi = 1'b0;
        for (int i = 0; i < 100 && !seen_hi; i++) begin
            if (c_clk) seen_hi = 1'b1;
            else       @(negedge clk);
        end
        chk("t5_reached_high", 32'(seen_hi), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5");
        exp_q.delete();
        @(negedge clk);
        chk("t5_done_in_rst", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_after", 32'(in_ready), 32'd1);
        chk("t5_done_after", 32'(done), 32'd0);
        // An unflushed FIFO would emit the stale tuple long before the late push.
        run_session("t5", 1, 30, UID_W'($urandom), DATA_W'($urandom), '0, -1, 1'b0);

        // 6: start while busy and in the done cycle are both ignored
        push_wait(UID_W'($urandom), DATA_W'($urandom), 1'b1);
        run_session("t6", 1, -1, '0, '0, '0, 5, 1'b1);

        // Randomized sessions
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(1, FIFO_DEPTH);
            for (int i = 0; i < n; i++)
                push_wait(UID_W'($urandom), DATA_W'($urandom), (i == n - 1));
            run_session("rnd", n, -1, '0, '0, '0, -1, 1'b0);
        end
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
